// File: rtl/tc_switch_bus_receiver_pkg.sv
// Shared helpers for the TC bus components: popcount, one-hot to index
// conversion and a clog2 that never returns a width below 1.
package tc_switch_bus_receiver_pkg;

  // Widest enable vector the helpers accept; callers zero-extend into this.
  localparam int unsigned MAX_SRC = 32;

  // Number of set bits in an enable vector.
  function automatic int unsigned popcount(input logic [MAX_SRC-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_SRC; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // Index of the lowest set bit. Only meaningful for a one-hot input.
  function automatic int unsigned onehot_index(input logic [MAX_SRC-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // Width of an index into n items, with a minimum of one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tc_switch_bus_receiver_sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter so full and empty are
// never ambiguous. The caller is responsible for not pushing when full
// unless it pops in the same cycle.
module tc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;

  // Storage, pointers and count; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rptr];
  assign full  = (count == (AW + 1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/tc_switch_bus_receiver.sv
// Receiver for a shared OR-bus driven by enable-gated switches. Single-driver
// cycles are queued with their source index; multi-driver cycles are dropped
// and recorded in sticky conflict flags.
module tc_switch_bus_receiver
  import tc_switch_bus_receiver_pkg::*;
#(
  parameter int    UUID      = 0,
  parameter string NAME      = "",
  parameter int    BIT_WIDTH = 1,
  parameter int    N_SRC     = 4,
  parameter int    DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_SRC-1:0]              en,
  input  logic [BIT_WIDTH-1:0]          in,
  output logic [BIT_WIDTH-1:0]          out,
  output logic [clog2_min1(N_SRC)-1:0]  out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          conflict,
  output logic [N_SRC-1:0]              conflict_mask,
  output logic                          overflow,
  output logic [$clog2(DEPTH):0]        count,
  input  logic                          clear
);

  localparam int SRC_W = clog2_min1(N_SRC);
  localparam int FW    = BIT_WIDTH + SRC_W;

  logic [MAX_SRC-1:0] en_wide;
  int unsigned        n_active;
  logic               push_req;
  logic               is_conflict;
  logic [SRC_W-1:0]   src;
  logic               pop;
  logic               push_ok;
  logic               drop;
  logic               full;
  logic               empty;
  logic [FW-1:0]      rdata;

  // Classify the cycle from the enables: idle, single driver or conflict.
  always_comb begin
    en_wide              = '0;
    en_wide[N_SRC-1:0]   = en;
    n_active             = popcount(en_wide);
    push_req             = (n_active == 1);
    is_conflict          = (n_active > 1);
    src                  = SRC_W'(onehot_index(en_wide));
  end

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  tc_sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_ok),
    .pop   (pop),
    .wdata ({src, in}),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign out     = rdata[BIT_WIDTH-1:0];
  assign out_src = rdata[FW-1:BIT_WIDTH];

  // Sticky flags; a new event in the same cycle as clear takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conflict      <= 1'b0;
      conflict_mask <= '0;
      overflow      <= 1'b0;
    end else begin
      if (is_conflict) begin
        conflict <= 1'b1;
        if (!conflict || clear) conflict_mask <= en;
      end else if (clear) begin
        conflict      <= 1'b0;
        conflict_mask <= '0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
